// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: zero-skew sync/position outputs, pixel
// clock-enable, one-cycle line/frame/vblank strobes and a wrapping frame counter.
module vga_timing_gen #(
    parameter int H_DISPLAY = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_BOTTOM  = 10,
    parameter int V_SYNC    = 2,
    parameter int V_TOP     = 33,
    parameter bit H_POL     = 1'b0,
    parameter bit V_POL     = 1'b0,
    parameter int HW        = 10,
    parameter int VW        = 10,
    parameter int FW        = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic [HW-1:0] hpos,
    output logic [VW-1:0] vpos,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank_start,
    output logic [FW-1:0] frame_count
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS  = HW'(H_DISPLAY);
    localparam logic [HW-1:0] HS_BEG = HW'(H_DISPLAY + H_FRONT);
    localparam logic [HW-1:0] HS_END = HW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS  = VW'(V_DISPLAY);
    localparam logic [VW-1:0] V_PREB = VW'(V_DISPLAY - 1);
    localparam logic [VW-1:0] VS_BEG = VW'(V_DISPLAY + V_BOTTOM);
    localparam logic [VW-1:0] VS_END = VW'(V_DISPLAY + V_BOTTOM + V_SYNC - 1);

    if (H_DISPLAY <= 0 || H_FRONT <= 0 || H_SYNC <= 0 || H_BACK <= 0 ||
        V_DISPLAY <= 0 || V_BOTTOM <= 0 || V_SYNC <= 0 || V_TOP <= 0) begin : g_bad_timing
        $error("vga_timing_gen: display, porch and sync values must all be non-zero");
    end
    if ((longint'(1) << HW) <= longint'(H_TOTAL - 1)) begin : g_bad_hw
        $error("vga_timing_gen: HW too narrow for H_TOTAL-1");
    end
    if ((longint'(1) << VW) <= longint'(V_TOTAL - 1)) begin : g_bad_vw
        $error("vga_timing_gen: VW too narrow for V_TOTAL-1");
    end

    function automatic logic in_hsync(input logic [HW-1:0] h);
        return (h >= HS_BEG) && (h <= HS_END);
    endfunction

    function automatic logic in_vsync(input logic [VW-1:0] v);
        return (v >= VS_BEG) && (v <= VS_END);
    endfunction

    logic [HW-1:0] hpos_q, hpos_d;
    logic [VW-1:0] vpos_q, vpos_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          line_q, line_d;
    logic          fstart_q, fstart_d;
    logic          vblank_q, vblank_d;

    // Sync and strobes are decoded from the next position so they land with it.
    always_comb begin
        hpos_d   = hpos_q;
        vpos_d   = vpos_q;
        frame_d  = frame_q;
        line_d   = 1'b0;
        fstart_d = 1'b0;
        vblank_d = 1'b0;
        if (pix_en) begin
            if (hpos_q == H_LAST) begin
                hpos_d = '0;
                line_d = 1'b1;
                if (vpos_q == V_LAST) begin
                    vpos_d   = '0;
                    frame_d  = frame_q + FW'(1);
                    fstart_d = 1'b1;
                end else begin
                    vpos_d   = vpos_q + VW'(1);
                    vblank_d = (vpos_q == V_PREB);
                end
            end else begin
                hpos_d = hpos_q + HW'(1);
            end
        end
        hsync_d = in_hsync(hpos_d) ? H_POL : ~H_POL;
        vsync_d = in_vsync(vpos_d) ? V_POL : ~V_POL;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hpos_q   <= '0;
            vpos_q   <= '0;
            frame_q  <= '0;
            hsync_q  <= ~H_POL;
            vsync_q  <= ~V_POL;
            line_q   <= 1'b0;
            fstart_q <= 1'b0;
            vblank_q <= 1'b0;
        end else begin
            hpos_q   <= hpos_d;
            vpos_q   <= vpos_d;
            frame_q  <= frame_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            line_q   <= line_d;
            fstart_q <= fstart_d;
            vblank_q <= vblank_d;
        end
    end

    assign hpos         = hpos_q;
    assign vpos         = vpos_q;
    assign frame_count  = frame_q;
    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign line_start   = line_q;
    assign frame_start  = fstart_q;
    assign vblank_start = vblank_q;
    assign display_on   = (hpos_q < H_VIS) && (vpos_q < V_VIS) && !reset;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: a wide-line/short-frame instance (A) and the tiny positive-polarity instance (B).
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, hs_a, vs_a, de_a, ls_a, fs_a, vb_a;
    logic [9:0] hp_a, vp_a;
    logic [11:0] fc_a;
    logic       rst_b, en_b, hs_b, vs_b, de_b, ls_b, fs_b, vb_b;
    logic [2:0] hp_b, vp_b;
    logic [1:0] fc_b;

    vga_timing_gen #(
        .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
        .V_DISPLAY(6), .V_BOTTOM(2), .V_SYNC(2), .V_TOP(2),
        .H_POL(1'b0), .V_POL(1'b0), .HW(10), .VW(10), .FW(12)
    ) dut_a (
        .clk(clk), .reset(rst_a), .pix_en(en_a), .hsync(hs_a), .vsync(vs_a),
        .display_on(de_a), .hpos(hp_a), .vpos(vp_a), .line_start(ls_a),
        .frame_start(fs_a), .vblank_start(vb_a), .frame_count(fc_a)
    );

    vga_timing_gen #(
        .H_DISPLAY(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_DISPLAY(3), .V_BOTTOM(1), .V_SYNC(1), .V_TOP(1),
        .H_POL(1'b1), .V_POL(1'b1), .HW(3), .VW(3), .FW(2)
    ) dut_b (
        .clk(clk), .reset(rst_b), .pix_en(en_b), .hsync(hs_b), .vsync(vs_b),
        .display_on(de_b), .hpos(hp_b), .vpos(vp_b), .line_start(ls_b),
        .frame_start(fs_b), .vblank_start(vb_b), .frame_count(fc_b)
    );

    typedef struct packed {
        int          tag;
        int          id;
        logic        dut;
        logic [37:0] v;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_push = 0;
    int   ka = 0;
    int   kb = 0;
    int   total = 0;
    int   bad = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input logic d, input int hp, input int vp,
                        input logic hs, input logic vs, input logic de,
                        input logic ls, input logic fs, input logic vb, input int fc);
        exp_t e;
        e.tag = cyc + 1;
        e.id  = n_push;
        e.dut = d;
        e.v   = {10'(hp), 10'(vp), hs, vs, de, ls, fs, vb, 12'(fc)};
        n_push++;
        q.push_back(e);
    endtask

    task automatic adv_a(input int k);
        while (ka < k) begin @(negedge clk); ka++; end
    endtask

    task automatic adv_b(input int k);
        while (kb < k) begin @(negedge clk); kb++; end
    endtask

    // Alternates pix_en starting with a 1 cycle; ends right after issuing advance k.
    task automatic alt_a(input int k);
        while (ka < k) begin
            @(negedge clk); en_a = 1'b1; ka++;
            if (ka < k) begin @(negedge clk); en_a = 1'b0; end
        end
    endtask

    // Monitor: pops scoreboard entries due this cycle, plus per-cycle decode invariants.
    exp_t        e;
    logic [37:0] act;
    logic        prev_ls_a = 1'b0, prev_ls_b = 1'b0;
    logic [2:0]  inv_exp, inv_act;
    always begin
        @(posedge clk); #1;
        while (q.size() > 0 && q[0].tag <= cyc) begin
            e = q.pop_front();
            act = e.dut ? {7'd0, hp_b, 7'd0, vp_b, hs_b, vs_b, de_b, ls_b, fs_b, vb_b, 10'd0, fc_b}
                        : {hp_a, vp_a, hs_a, vs_a, de_a, ls_a, fs_a, vb_a, fc_a};
            total++;
            if (act !== e.v || e.tag != cyc) begin
                bad++;
                $display("FAIL chk%0d dut_%s cyc=%0d got hp=%0d vp=%0d hs/vs/de/ls/fs/vb=%b fc=%0d want hp=%0d vp=%0d hs/vs/de/ls/fs/vb=%b fc=%0d",
                         e.id, e.dut ? "b" : "a", cyc, act[37:28], act[27:18], act[17:12], act[11:0],
                         e.v[37:28], e.v[27:18], e.v[17:12], e.v[11:0]);
            end
        end
        inv_exp = {(hp_a < 10'd640) && (vp_a < 10'd6) && !rst_a,
                   !((hp_a >= 10'd656) && (hp_a <= 10'd751)),
                   !((vp_a >= 10'd8) && (vp_a <= 10'd9))};
        inv_act = {de_a, hs_a, vs_a};
        total++;
        if (inv_act !== inv_exp) begin
            bad++;
            $display("FAIL align_a cyc=%0d hp=%0d vp=%0d de/hs/vs got=%b want=%b", cyc, hp_a, vp_a, inv_act, inv_exp);
        end
        inv_exp = {(hp_b < 3'd4) && (vp_b < 3'd3) && !rst_b,
                   (hp_b >= 3'd5) && (hp_b <= 3'd6),
                   vp_b == 3'd4};
        inv_act = {de_b, hs_b, vs_b};
        total++;
        if (inv_act !== inv_exp) begin
            bad++;
            $display("FAIL align_b cyc=%0d hp=%0d vp=%0d de/hs/vs got=%b want=%b", cyc, hp_b, vp_b, inv_act, inv_exp);
        end
        if (ls_a) begin
            total++;
            if (prev_ls_a) begin
                bad++;
                $display("FAIL ls_width_a cyc=%0d got two-cycle line_start want one", cyc);
            end
        end
        if (ls_b) begin
            total++;
            if (prev_ls_b) begin
                bad++;
                $display("FAIL ls_width_b cyc=%0d got two-cycle line_start want one", cyc);
            end
        end
        prev_ls_a = ls_a;
        prev_ls_b = ls_b;
        if (done) begin
            total++;
            if (q.size() != 0) begin
                bad++;
                $display("FAIL sb_drain got %0d pending entries want 0", q.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_a = 1'b1; en_a = 1'b1;
        rst_b = 1'b1; en_b = 1'b1;

        // Instance B: small raster, positive polarity, 2-bit frame counter
        @(negedge clk); push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); rst_b = 1'b0; kb = 1; push(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);
        adv_b(5);   push(1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        adv_b(7);   push(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        adv_b(8);   push(1, 0, 1, 0, 0, 1, 1, 0, 0, 0);
        adv_b(24);  push(1, 0, 3, 0, 0, 0, 1, 0, 1, 0);
        adv_b(32);  push(1, 0, 4, 0, 1, 0, 1, 0, 0, 0);
        adv_b(40);  push(1, 0, 5, 0, 0, 0, 1, 0, 0, 0);
        adv_b(47);  push(1, 7, 5, 0, 0, 0, 0, 0, 0, 0);
        adv_b(48);  push(1, 0, 0, 0, 0, 1, 1, 1, 0, 1);
        adv_b(96);  push(1, 0, 0, 0, 0, 1, 1, 1, 0, 2);
        adv_b(144); push(1, 0, 0, 0, 0, 1, 1, 1, 0, 3);
        adv_b(192); push(1, 0, 0, 0, 0, 1, 1, 1, 0, 0);
        adv_b(193); push(1, 1, 0, 0, 0, 1, 0, 0, 0, 0);

        // Instance A: 800-pixel lines, 12-line frames (9600 clocks)
        @(negedge clk); push(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); rst_a = 1'b0; ka = 1; push(0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        adv_a(639);   push(0, 639, 0, 1, 1, 1, 0, 0, 0, 0);
        adv_a(640);   push(0, 640, 0, 1, 1, 0, 0, 0, 0, 0);
        adv_a(655);   push(0, 655, 0, 1, 1, 0, 0, 0, 0, 0);
        adv_a(656);   push(0, 656, 0, 0, 1, 0, 0, 0, 0, 0);
        adv_a(751);   push(0, 751, 0, 0, 1, 0, 0, 0, 0, 0);
        adv_a(752);   push(0, 752, 0, 1, 1, 0, 0, 0, 0, 0);
        adv_a(799);   push(0, 799, 0, 1, 1, 0, 0, 0, 0, 0);
        adv_a(800);   push(0, 0, 1, 1, 1, 1, 1, 0, 0, 0);
        adv_a(801);   push(0, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        adv_a(4800);  push(0, 0, 6, 1, 1, 0, 1, 0, 1, 0);
        adv_a(6400);  push(0, 0, 8, 1, 0, 0, 1, 0, 0, 0);
        adv_a(7999);  push(0, 799, 9, 1, 0, 0, 0, 0, 0, 0);
        adv_a(8000);  push(0, 0, 10, 1, 1, 0, 1, 0, 0, 0);
        adv_a(9599);  push(0, 799, 11, 1, 1, 0, 0, 0, 0, 0);
        adv_a(9600);  push(0, 0, 0, 1, 1, 1, 1, 1, 0, 1);
        adv_a(9601);  push(0, 1, 0, 1, 1, 1, 0, 0, 0, 1);
        adv_a(19199); push(0, 799, 11, 1, 1, 0, 0, 0, 0, 1);
        adv_a(19200); push(0, 0, 0, 1, 1, 1, 1, 1, 0, 2);
        adv_a(21700); push(0, 100, 3, 1, 1, 1, 0, 0, 0, 2);

        // Mid-frame reset held for 5 cycles
        repeat (5) begin
            @(negedge clk); rst_a = 1'b1; push(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        end
        @(negedge clk); rst_a = 1'b0; ka = 1; push(0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        adv_a(9599); push(0, 799, 11, 1, 1, 0, 0, 0, 0, 0);

        // Reset on the frame-wrap cycle wins over the wrap
        @(negedge clk); rst_a = 1'b1; push(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        @(negedge clk); rst_a = 1'b0; ka = 1; push(0, 1, 0, 1, 1, 1, 0, 0, 0, 0);
        adv_a(9599); push(0, 799, 11, 1, 1, 0, 0, 0, 0, 0);
        adv_a(9600); push(0, 0, 0, 1, 1, 1, 1, 1, 0, 1);

        // pix_en alternating: hold on 0 cycles, one-clock strobes
        @(negedge clk); en_a = 1'b0; push(0, 0, 0, 1, 1, 1, 0, 0, 0, 1);
        alt_a(10256); push(0, 656, 0, 0, 1, 0, 0, 0, 0, 1);
        @(negedge clk); en_a = 1'b0; push(0, 656, 0, 0, 1, 0, 0, 0, 0, 1);
        alt_a(10399); push(0, 799, 0, 1, 1, 0, 0, 0, 0, 1);
        @(negedge clk); en_a = 1'b0; push(0, 799, 0, 1, 1, 0, 0, 0, 0, 1);
        alt_a(10400); push(0, 0, 1, 1, 1, 1, 1, 0, 0, 1);
        @(negedge clk); en_a = 1'b0; push(0, 0, 1, 1, 1, 1, 0, 0, 0, 1);
        @(negedge clk); en_a = 1'b1; ka++; push(0, 1, 1, 1, 1, 1, 0, 0, 0, 1);

        repeat (3) @(negedge clk);
        done = 1'b1;
    end

endmodule
